// File: rtl/dpi_ctx_pkg.sv
// Shared types and helpers for the per-stream regex context tracker.
package dpi_ctx_pkg;

  localparam int unsigned DefNumStreams = 64;
  localparam int unsigned DefStateW     = 11;
  localparam int unsigned DefCntW       = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StActive,
    StCommit
  } ctx_state_e;

  // Add a single bit to val, clamping at 2^width-1 (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (inc && (val < max_v)) ? (val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/dpi_ctx_ram.sv
// Simple 1W/1R context RAM with synchronous read; a read that collides with a
// write to the same address returns the pre-write contents. Not reset.
module dpi_ctx_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 11,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dpi_stream_ctx_tracker.sv
// Per-stream save/restore of regex engine state plus packet match counting.
// Optional macro DPI_CTX_RDBK_EN adds per-stream match counters readable via
// rd_sid/rd_count.
module dpi_stream_ctx_tracker
  import dpi_ctx_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = DefNumStreams,
  parameter int unsigned SID_W       = $clog2(NUM_STREAMS),
  parameter int unsigned STATE_W     = DefStateW,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sop,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               new_stream,
  input  logic               enable,
  input  logic               eop,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  output logic               fired,
  output logic [CNT_W-1:0]   total_count,
  output logic               busy
`ifdef DPI_CTX_RDBK_EN
  ,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count
`endif
);

  ctx_state_e         state_q, state_d;
  logic               fired_q, fired_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [SID_W-1:0]   sid_q;
  logic               new_q, en_q;
  logic [STATE_W-1:0] cap_q;
  logic               fwd_q;
  logic [STATE_W-1:0] fwd_state_q;
  logic [STATE_W-1:0] ram_rdata;
  logic               ram_we;

  // Commit writes only for enabled packets; a reset cycle never writes.
  assign ram_we = rst_n && (state_q == StCommit) && en_q;

  // Next-state, fired and total_count update.
  always_comb begin
    state_d = state_q;
    fired_d = fired_q;
    total_d = total_q;
    unique case (state_q)
      StIdle:   ;
      StLoad:   state_d = StActive;
      StActive: begin
        fired_d = fired_q | eng_accept;
        if (eop) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        if (en_q) total_d = CNT_W'(sat_add(32'(total_q), fired_q, CNT_W));
        else      fired_d = 1'b0;
      end
      default:  state_d = StIdle;
    endcase
    // A new packet start aborts whatever is in flight (a commit still completes).
    if (sop) begin
      state_d = StLoad;
      fired_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fired_q <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      fired_q <= fired_d;
      total_q <= total_d;
    end
  end

  // Packet attributes, captured end state and write-forwarding bookkeeping.
  always_ff @(posedge clk) begin
    if (sop) begin
      sid_q       <= stream_id;
      new_q       <= new_stream;
      en_q        <= enable;
      // The RAM read issued now sees the old contents if COMMIT writes this sid.
      fwd_q       <= (state_q == StCommit) && en_q && (stream_id == sid_q);
      fwd_state_q <= cap_q;
    end
    if ((state_q == StActive) && eop && !sop) cap_q <= eng_state_out;
  end

  dpi_ctx_ram #(
    .Depth (NUM_STREAMS),
    .Width (STATE_W),
    .AddrW (SID_W)
  ) u_state_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (sid_q),
    .wdata (cap_q),
    .raddr (stream_id),
    .rdata (ram_rdata)
  );

  // Engine load value and status outputs.
  always_comb begin
    eng_state_in = '0;
    if (state_q == StLoad && !new_q) eng_state_in = fwd_q ? fwd_state_q : ram_rdata;
  end

  assign eng_state_in_vld = (state_q == StLoad);
  assign fired            = fired_q;
  assign total_count      = total_q;
  assign busy             = (state_q != StIdle);

`ifdef DPI_CTX_RDBK_EN
  logic [CNT_W-1:0] cnt_rdata, cnt_base_q, cnt_fwd_q, cnt_start, cnt_wdata;

  assign cnt_start = new_q ? {CNT_W{1'b0}} : cnt_base_q;
  assign cnt_wdata = CNT_W'(sat_add(32'(cnt_start), fired_q, CNT_W));

  // Per-stream counter base, fetched during LOAD with the same forwarding as state.
  always_ff @(posedge clk) begin
    if (sop) cnt_fwd_q <= cnt_wdata;
    if (state_q == StLoad) cnt_base_q <= fwd_q ? cnt_fwd_q : cnt_rdata;
  end

  // Two identical counter copies: one feeds commit, the other serves readback.
  dpi_ctx_ram #(
    .Depth (NUM_STREAMS),
    .Width (CNT_W),
    .AddrW (SID_W)
  ) u_cnt_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (sid_q),
    .wdata (cnt_wdata),
    .raddr (stream_id),
    .rdata (cnt_rdata)
  );

  dpi_ctx_ram #(
    .Depth (NUM_STREAMS),
    .Width (CNT_W),
    .AddrW (SID_W)
  ) u_cnt_rdbk_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (sid_q),
    .wdata (cnt_wdata),
    .raddr (rd_sid),
    .rdata (rd_count)
  );
`endif

endmodule

// File: tb/tb_dpi_stream_ctx_tracker.sv
// Randomized packet-level bench for dpi_stream_ctx_tracker with a stream
// context / counter reference model.
module tb_dpi_stream_ctx_tracker;

  localparam int unsigned NS   = 16;
  localparam int unsigned SW   = 4;
  localparam int unsigned STW  = 11;
  localparam int unsigned CW   = 5;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sop = 1'b0, new_stream = 1'b0, enable = 1'b0, eop = 1'b0;
  logic           eng_accept = 1'b0;
  logic [SW-1:0]  stream_id = '0;
  logic [STW-1:0] eng_state_out = '0;
  logic [STW-1:0] eng_state_in;
  logic           eng_state_in_vld, fired, busy;
  logic [CW-1:0]  total_count;
`ifdef DPI_CTX_RDBK_EN
  logic [SW-1:0]  rd_sid = '0;
  logic [CW-1:0]  rd_count;
`endif

  dpi_stream_ctx_tracker #(
    .NUM_STREAMS (NS),
    .STATE_W     (STW),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sop              (sop),
    .stream_id        (stream_id),
    .new_stream       (new_stream),
    .enable           (enable),
    .eop              (eop),
    .eng_state_out    (eng_state_out),
    .eng_accept       (eng_accept),
    .eng_state_in     (eng_state_in),
    .eng_state_in_vld (eng_state_in_vld),
    .fired            (fired),
    .total_count      (total_count),
    .busy             (busy)
`ifdef DPI_CTX_RDBK_EN
    ,
    .rd_sid           (rd_sid),
    .rd_count         (rd_count)
`endif
  );

  always #5 clk = ~clk;

  int total_n = 0;
  int bad_n   = 0;

  // Reference model: saved state / counter per stream, global count.
  int unsigned ctx_m [NS];
  int unsigned cnt_m [NS];
  bit          known [NS];
  int unsigned total_m;
  // Commit recorded in the COMMIT cycle, applied at the following edge.
  bit          pc_v;
  int unsigned pc_sid, pc_state, pc_cnt, pc_total;
  // Attributes of the packet most recently started.
  int unsigned nxt_sid;
  bit          nxt_new, nxt_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Advance one clock; model commits become visible at this edge.
  task automatic tick();
`ifdef DPI_CTX_RDBK_EN
    bit          rv;
    int unsigned re;
    rv = known[rd_sid];
    re = cnt_m[rd_sid];
`endif
    if (pc_v) begin
      ctx_m[pc_sid] = pc_state;
      cnt_m[pc_sid] = pc_cnt;
      known[pc_sid] = 1'b1;
      total_m       = pc_total;
      pc_v          = 1'b0;
    end
    @(posedge clk);
    #1;
`ifdef DPI_CTX_RDBK_EN
    if (rv) check("rd_count", rd_count, re);
    rd_sid = SW'($urandom_range(0, NS - 1));
`endif
  endtask

  task automatic noise();
    sop           = 1'b0;
    eop           = 1'($urandom_range(0, 1));
    eng_accept    = 1'($urandom_range(0, 1));
    eng_state_out = STW'($urandom);
  endtask

  task automatic drive_sop(input int unsigned pref, input bit use_pref);
    int unsigned s;
    bit          n;
    s = use_pref ? pref : $urandom_range(0, NS - 1);
    n = ($urandom_range(0, 4) == 0);
    if (!(known[s] || (pc_v && pc_sid == s))) n = 1'b1;
    nxt_sid       = s;
    nxt_new       = n;
    nxt_en        = ($urandom_range(0, 4) != 0);
    sop           = 1'b1;
    stream_id     = SW'(s);
    new_stream    = n;
    enable        = nxt_en;
    eop           = 1'($urandom_range(0, 1));
    eng_accept    = 1'($urandom_range(0, 1));
    eng_state_out = STW'($urandom);
  endtask

  initial begin
    bit          sop_pending, aborted, cur_new, cur_en, fired_m, fired_hold;
    int unsigned cur_sid, final_st;
    int          len, abort_k, gaps;

    foreach (known[i]) begin
      known[i] = 1'b0;
      ctx_m[i] = 0;
      cnt_m[i] = 0;
    end
    total_m = 0;
    pc_v    = 1'b0;
    final_st = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_total", total_count, 0);
    check("rst_fired", fired, 0);
    check("rst_vld", eng_state_in_vld, 0);
    check("rst_state_in", eng_state_in, 0);
    rst_n = 1'b1;

    fired_hold  = 1'b0;
    sop_pending = 1'b0;
    for (int p = 0; p < 400; p++) begin
      if (!sop_pending) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g <= gaps; g++) begin
          check("idle_busy", busy, 0);
          check("idle_vld", eng_state_in_vld, 0);
          check("idle_fired", fired, fired_hold);
          check("idle_total", total_count, total_m);
          if (g == gaps) drive_sop(0, 1'b0);
          else           noise();
          tick();
        end
      end
      cur_sid = nxt_sid;
      cur_new = nxt_new;
      cur_en  = nxt_en;

      // LOAD cycle
      check("load_vld", eng_state_in_vld, 1);
      check("load_state", eng_state_in, cur_new ? 0 : ctx_m[cur_sid]);
      check("load_fired", fired, 0);
      sop = 1'b0; eop = 1'b0; eng_accept = 1'b0; eng_state_out = STW'($urandom);
      tick();

      // ACTIVE cycles
      len     = $urandom_range(1, 6);
      abort_k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      fired_m = 1'b0;
      aborted = 1'b0;
      for (int k = 0; k < len; k++) begin
        check("act_fired", fired, fired_m);
        check("act_vld", eng_state_in_vld, 0);
        check("act_busy", busy, 1);
        if (k == abort_k) begin
          drive_sop(cur_sid, 1'($urandom_range(0, 1)));
          tick();
          aborted = 1'b1;
          break;
        end
        eng_accept    = ($urandom_range(0, 3) == 0);
        eop           = (k == len - 1);
        eng_state_out = STW'($urandom);
        fired_m       = fired_m | eng_accept;
        if (eop) final_st = eng_state_out;
        tick();
      end
      if (aborted) begin
        sop_pending = 1'b1;
        continue;
      end

      // COMMIT cycle
      check("cmt_fired", fired, fired_m);
      check("cmt_total", total_count, total_m);
      check("cmt_busy", busy, 1);
      if (cur_en) begin
        pc_v     = 1'b1;
        pc_sid   = cur_sid;
        pc_state = final_st;
        pc_cnt   = sat((cur_new ? 0 : cnt_m[cur_sid]) + fired_m);
        pc_total = sat(total_m + fired_m);
      end
      fired_hold = cur_en ? fired_m : 1'b0;
`ifdef DPI_CTX_RDBK_EN
      if ($urandom_range(0, 1) == 0) rd_sid = SW'(cur_sid);
`endif
      if ($urandom_range(0, 2) == 0) begin
        drive_sop(cur_sid, 1'($urandom_range(0, 1)));
        tick();
        check("b2b_total", total_count, total_m);
        sop_pending = 1'b1;
      end else begin
        noise();
        tick();
        check("post_total", total_count, total_m);
        sop_pending = 1'b0;
      end
    end

    // Reset in the middle of an accepting packet.
    if (!sop_pending) begin
      drive_sop(0, 1'b0);
      tick();
    end
    sop = 1'b0; eop = 1'b0; eng_accept = 1'b0;
    tick();
    eng_accept = 1'b1;
    tick();
    rst_n = 1'b0;
    eop   = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_total", total_count, 0);
    check("mid_rst_fired", fired, 0);
    check("mid_rst_vld", eng_state_in_vld, 0);
    rst_n = 1'b1;
    eop = 1'b0; eng_accept = 1'b0;
    tick();
    check("after_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
